// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// shared instruction/data memory.
//   iord      : address select, 0 = PC, 1 = ALUOut
//   mem_read  : read request
//   mem_write : write request
//   mem_ready : memory completes the current access this cycle
interface multicycle_controller_if;
    logic iord;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (
        output iord,
        output mem_read,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  iord,
        input  mem_read,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core. Walks each instruction
// through fetch, decode, execute, memory and write-back, driving the
// datapath mux selects and write enables, and stalls on mem_ready.
// Ports:
//   clk, reset (async, active-low)
//   opcode, bcond, halt_cond      : datapath status inputs
//   mem (master)                  : iord / mem_read / mem_write / mem_ready
//   pc_write, ir_write, pc_source : PC/IR controls
//   alu_src_a, alu_src_b, alu_op  : ALU operand and operation selects
//   reg_write, wb_sel             : register-file write-back controls
//   inst_done, halted, state      : status and debug
//
// state | meaning
// ------+--------------------------------------------
// RST   | just out of reset, no outputs
// IF    | fetch, waits on mem_ready, PC <= PC+4
// ID    | decode, ALUOut <= old_pc + imm
// EX    | execute / branch / jump resolution
// MEM   | load or store access, waits on mem_ready
// WB    | register write-back
// HALT  | stopped until reset
//
// Outputs are decoded combinationally from the state register and the
// live inputs, so the fetch/load enables coincide with mem_ready.
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic                     bcond,
    input  logic                     halt_cond,
    multicycle_controller_if.master  mem,
    output logic                     pc_write,
    output logic                     ir_write,
    output logic                     pc_source,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic                     reg_write,
    output logic [1:0]               wb_sel,
    output logic                     inst_done,
    output logic                     halted,
    output logic [2:0]               state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   iord_c;
    logic   mem_read_c;
    logic   mem_write_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_IF;
        iord_c      = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        pc_source   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        reg_write   = 1'b0;
        wb_sel      = 2'b00;
        inst_done   = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF: begin
                mem_read_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    state_d   = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                state_d   = S_EX;
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 2'b01;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b11;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 2'b01;
                        alu_op    = 2'b01;
                        pc_source = 1'b1;
                        pc_write  = bcond;
                        inst_done = 1'b1;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        inst_done = 1'b1;
                    end
                    OP_JALR: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        inst_done = 1'b1;
                    end
                    OP_ECALL: begin
                        // Halting ecall does not retire
                        if (halt_cond) begin
                            state_d = S_HALT;
                        end else begin
                            inst_done = 1'b1;
                        end
                    end
                    default: begin
                        inst_done = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : S_IF;
                    end
                endcase
            end
            S_MEM: begin
                iord_c = 1'b1;
                // Only load and store reach MEM; the MDR load is done by the
                // datapath on mem_read & mem_ready, so ir_write stays low.
                if (opcode == OP_STORE) begin
                    mem_write_c = 1'b1;
                    if (mem.mem_ready) begin
                        inst_done = 1'b1;
                        state_d   = S_IF;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    mem_read_c = 1'b1;
                    state_d    = mem.mem_ready ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                inst_done = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_IF;
        endcase
    end

    assign mem.iord      = iord_c;
    assign mem.mem_read  = mem_read_c;
    assign mem.mem_write = mem_write_c;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is
// expanded at transaction level into a list of per-cycle records (inputs
// plus the outputs the instruction's step must show); one process drives
// the inputs and compares every cycle against the record.
module tb_multicycle_controller;

    localparam bit HALT_ON_ILLEGAL = 1'b0;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_cond;
    logic       pc_write, ir_write, pc_source, reg_write, inst_done, halted;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [2:0] state;

    multicycle_controller_if mem_bus ();

    multicycle_controller #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .bcond     (bcond),
        .halt_cond (halt_cond),
        .mem       (mem_bus),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .pc_source (pc_source),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .inst_done (inst_done),
        .halted    (halted),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_source;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       inst_done;
        logic       halted;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic       mr;
        logic       bc;
        logic       hc;
        logic [6:0] op;
        outs_t      exp;
    } rec_t;

    rec_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    task automatic add(input logic rst_n, input logic mr, input logic bc,
                       input logic hc, input logic [6:0] op, input outs_t e);
        rec_t r;
        r.rst_n = rst_n;
        r.mr    = mr;
        r.bc    = bc;
        r.hc    = hc;
        r.op    = op;
        r.exp   = e;
        q.push_back(r);
    endtask

    // n cycles held in reset, then one cycle released but still in RST
    task automatic plan_reset(input int n);
        outs_t e;
        e = '0;
        for (int i = 0; i < n; i++) add(1'b0, r1(), r1(), r1(), rop(), e);
        add(1'b1, r1(), r1(), r1(), rop(), e);
    endtask

    task automatic plan_halt(input int n);
        outs_t e;
        e        = '0;
        e.st     = 3'd6;
        e.halted = 1'b1;
        for (int i = 0; i < n; i++) add(1'b1, r1(), r1(), r1(), rop(), e);
    endtask

    // Expands one instruction into its cycles; len is the cycle count from
    // the first IF cycle to the retiring (or halting) cycle.
    task automatic plan_instr(input logic [6:0] op, input int ifw, input int memw,
                              input logic bc, input logic hc, input bit cut,
                              output int len, output bit halts);
        outs_t e;
        bit    to_mem, to_wb, is_store;
        len      = 0;
        halts    = 1'b0;
        to_mem   = 1'b0;
        to_wb    = 1'b0;
        is_store = (op == OP_STORE);
        for (int i = 0; i < ifw; i++) begin
            e = '0; e.st = 3'd1; e.mem_read = 1'b1;
            add(1'b1, 1'b0, r1(), r1(), rop(), e); len++;
        end
        e = '0; e.st = 3'd1; e.mem_read = 1'b1; e.ir_write = 1'b1;
        e.pc_write = 1'b1; e.alu_b = 2'b01;
        add(1'b1, 1'b1, r1(), r1(), rop(), e); len++;
        e = '0; e.st = 3'd2; e.alu_a = 2'b10; e.alu_b = 2'b10;
        add(1'b1, r1(), r1(), r1(), op, e); len++;
        e = '0; e.st = 3'd3;
        case (op)
            OP_R:      begin e.alu_a = 2'b01; e.alu_op = 2'b10; to_wb = 1'b1; end
            OP_I:      begin e.alu_a = 2'b01; e.alu_b = 2'b10; e.alu_op = 2'b11; to_wb = 1'b1; end
            OP_LOAD,
            OP_STORE:  begin e.alu_a = 2'b01; e.alu_b = 2'b10; to_mem = 1'b1; end
            OP_BRANCH: begin
                e.alu_a = 2'b01; e.alu_op = 2'b01; e.pc_source = 1'b1;
                e.pc_write = bc; e.inst_done = 1'b1;
            end
            OP_JAL: begin
                e.pc_write = 1'b1; e.pc_source = 1'b1; e.reg_write = 1'b1;
                e.wb_sel = 2'b10; e.inst_done = 1'b1;
            end
            OP_JALR: begin
                e.alu_a = 2'b01; e.alu_b = 2'b10; e.pc_write = 1'b1;
                e.reg_write = 1'b1; e.wb_sel = 2'b10; e.inst_done = 1'b1;
            end
            OP_ECALL:  begin if (hc) halts = 1'b1; else e.inst_done = 1'b1; end
            default:   begin e.inst_done = 1'b1; halts = HALT_ON_ILLEGAL; end
        endcase
        add(1'b1, r1(), bc, hc, op, e); len++;
        if (to_mem) begin
            e = '0; e.st = 3'd4; e.iord = 1'b1;
            e.mem_write = is_store; e.mem_read = !is_store;
            for (int i = 0; i < memw; i++) begin
                add(1'b1, 1'b0, r1(), r1(), op, e); len++;
            end
            if (cut) return;
            e.inst_done = is_store;
            add(1'b1, 1'b1, r1(), r1(), op, e); len++;
            to_wb = !is_store;
        end
        if (to_wb) begin
            e = '0; e.st = 3'd5; e.reg_write = 1'b1; e.inst_done = 1'b1;
            e.wb_sel = (op == OP_LOAD) ? 2'b01 : 2'b00;
            add(1'b1, r1(), r1(), r1(), op, e); len++;
        end
    endtask

    task automatic run_queue();
        rec_t  r;
        outs_t act;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            reset             = r.rst_n;
            mem_bus.mem_ready = r.mr;
            bcond             = r.bc;
            halt_cond         = r.hc;
            opcode            = r.op;
            #1;
            act.st        = state;
            act.pc_write  = pc_write;
            act.iord      = mem_bus.iord;
            act.mem_read  = mem_bus.mem_read;
            act.mem_write = mem_bus.mem_write;
            act.ir_write  = ir_write;
            act.pc_source = pc_source;
            act.alu_a     = alu_src_a;
            act.alu_b     = alu_src_b;
            act.alu_op    = alu_op;
            act.reg_write = reg_write;
            act.wb_sel    = wb_sel;
            act.inst_done = inst_done;
            act.halted    = halted;
            checks++;
            if (act !== r.exp) begin
                errors++;
                $display("FAIL cycle %0d: got state=%0d outs=%h, required state=%0d outs=%h",
                         cyc, act.st, act, r.exp.st, r.exp);
            end
            if (inst_done === 1'b1) done_cnt++;
            cyc++;
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    logic [6:0] op_pool [10];

    initial begin
        int len;
        bit halts;
        reset             = 1'b0;
        opcode            = '0;
        bcond             = 1'b0;
        halt_cond         = 1'b0;
        mem_bus.mem_ready = 1'b0;
        op_pool = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                    OP_JALR, OP_ECALL, 7'b0000000, 7'b1111111};

        // R-type from reset, zero-wait
        plan_reset(2);
        plan_instr(OP_R, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_rtype", len, 4);
        done_cnt = 0;
        run_queue();
        check_int("done_rtype", done_cnt, 1);

        // Load with 2 IF waits and 3 MEM waits
        plan_instr(OP_LOAD, 2, 3, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_load_waits", len, 10);
        done_cnt = 0;
        run_queue();
        check_int("done_load", done_cnt, 1);

        plan_instr(OP_LOAD, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_load", len, 5);
        plan_instr(OP_STORE, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_store", len, 4);
        plan_instr(OP_I, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_itype", len, 4);
        plan_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0, 1'b0, len, halts);
        check_int("lat_branch_taken", len, 3);
        plan_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_branch_not", len, 3);
        plan_instr(OP_JAL, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_jal", len, 3);
        plan_instr(OP_JALR, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_jalr", len, 3);
        plan_instr(OP_ECALL, 0, 0, 1'b0, 1'b0, 1'b0, len, halts);
        check_int("lat_ecall", len, 3);
        done_cnt = 0;
        run_queue();
        check_int("done_mix", done_cnt, 8);

        // Halting ecall, then 20 cycles of random inputs in HALT
        plan_instr(OP_ECALL, 0, 0, 1'b0, 1'b1, 1'b0, len, halts);
        check_int("ecall_halts", int'(halts), 1);
        plan_halt(20);
        done_cnt = 0;
        run_queue();
        check_int("done_halt", done_cnt, 0);

        // Reset during a store wait, then a fresh fetch
        plan_reset(1);
        plan_instr(OP_STORE, 0, 2, 1'b0, 1'b0, 1'b1, len, halts);
        check_int("lat_store_cut", len, 5);
        plan_reset(2);
        plan_instr(OP_R, 1, 0, 1'b0, 1'b0, 1'b0, len, halts);
        run_queue();

        // Randomised instruction stream
        for (int n = 0; n < 80; n++) begin
            plan_instr(op_pool[$urandom_range(0, 9)], $urandom_range(0, 3),
                       $urandom_range(0, 3), r1(), r1(), 1'b0, len, halts);
            if (halts) begin
                plan_halt($urandom_range(1, 5));
                plan_reset($urandom_range(1, 2));
            end
            run_queue();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RV32I core. It walks each instruction through the fetch, decode, execute, memory and write-back steps. Every cycle it drives the select lines of the shared datapath multiplexers: the 2:1 selects and the 4:1 ALU operand selects. It also drives the PC, IR, memory and register-file write enables, and it stalls on a memory ready handshake. It sits between the instruction register and the datapath and replaces the single-cycle combinational control unit.

## Interface
- HALT_ON_ILLEGAL, 0, when 1 an unrecognised opcode in EX goes to HALT; when 0 it retires as a NOP.
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; low forces state RST immediately.
- opcode  in  7  IR[6:0]; stable from the cycle after the ir_write edge.
- bcond  in  1  ALU branch-condition result for the current cycle.
- halt_cond  in  1  ecall halt qualifier (x17 == 10), supplied by the datapath.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable (already qualified by bcond for branches).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR/MDR load enable for fetch.
- pc_source  out  1  PC next select: 0 = live ALU result, 1 = ALUOut.
- alu_src_a  out  2  4:1 select: 00 = PC, 01 = rs1, 10 = old_pc, 11 = unused (0).
- alu_src_b  out  2  4:1 select: 00 = rs2, 01 = constant 4, 10 = imm, 11 = unused.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  write-back select: 00 = ALUOut, 01 = MDR, 10 = PC.
- inst_done  out  1  one-cycle pulse on the final cycle of each instruction.
- halted  out  1  high while in HALT.
- state  out  3  current state encoding, for debug.

## Operation
- States and encodings: RST = 0, IF = 1, ID = 2, EX = 3, MEM = 4, WB = 5, HALT = 6. Encoding 7 is illegal and its next state is IF.
- Every output not listed for a state is 0. Outputs are decoded combinationally from the state register, opcode, bcond and mem_ready.
- RST: no outputs asserted. Next state is IF.
- IF: iord=0, mem_read=1.
  - If mem_ready: also assert ir_write=1, pc_write=1, pc_source=0, alu_src_a=00, alu_src_b=01, alu_op=00 (PC <= PC+4). Next state ID.
  - Otherwise stay in IF.
- ID: alu_src_a=10, alu_src_b=10, alu_op=00, so ALUOut <= old_pc + imm. Next state EX.
- EX, by opcode:
  - 0110011 (R-type): a=01, b=00, op=10. Next WB.
  - 0010011 (I-type): a=01, b=10, op=11. Next WB.
  - 0000011 (load) and 0100011 (store): a=01, b=10, op=00. Next MEM.
  - 1100011 (branch): a=01, b=00, op=01, pc_source=1, pc_write=bcond, inst_done=1. Next IF.
  - 1101111 (JAL): pc_write=1, pc_source=1, reg_write=1, wb_sel=10, inst_done=1. Next IF.
  - 1100111 (JALR): a=01, b=10, op=00, pc_write=1, pc_source=0, reg_write=1, wb_sel=10, inst_done=1. Next IF. The datapath clears the target LSB.
  - 1110011 (ecall): if halt_cond, next HALT; otherwise inst_done=1, next IF.
  - Any other opcode: inst_done=1; next HALT if HALT_ON_ILLEGAL, else IF.
- MEM: iord=1.
  - Load: mem_read=1. When mem_ready, ir_write stays 0 (the MDR is loaded by the datapath on mem_read & mem_ready) and next is WB; otherwise stay in MEM.
  - Store: mem_write=1. When mem_ready, inst_done=1 and next is IF; otherwise stay in MEM.
- WB: reg_write=1, wb_sel = 01 for load, 00 otherwise, inst_done=1. Next IF.
- HALT: halted=1. Stays in HALT until reset; inputs are ignored.

## Timing
- Reset asserted (low): state = RST asynchronously; every output is 0, including halted and inst_done.
- First rising edge after reset deasserts: state goes to IF. The first mem_read is asserted one cycle after release.
- Latency with zero-wait memory (mem_ready held high), in cycles: branch, JAL, JALR and ecall 3; store 4; R-type and I-type 4; load 5.
- Each wait cycle (mem_ready low) in IF or MEM adds exactly one cycle. Request outputs stay asserted and stable while waiting.
- mem_ready sampled in any state other than IF or MEM has no effect.
- pc_write in IF and ir_write are asserted only in the same cycle as mem_ready, so the PC advances exactly once per fetch.
- Reset asserted mid-instruction, including during a memory wait, drops all outputs in the same cycle with no further write enables.
- inst_done rises exactly once per retired instruction. It does not rise on the ecall that enters HALT.

## Test plan
- Reset, then R-type opcode 0110011 with mem_ready=1: state sequence RST,IF,ID,EX,WB,IF. reg_write=1 and wb_sel=00 only in WB. One inst_done pulse.
- Load 0000011 with mem_ready low for 2 cycles in IF and 3 in MEM: 10 cycles from IF to retire. mem_read is held throughout, iord=1 only in MEM, wb_sel=01 in WB.
- Branch 1100011: with bcond=1, pc_write=1 and pc_source=1 in EX. With bcond=0, pc_write=0 and the next state is still IF.
- JAL 1101111 and JALR 1100111: in EX both assert reg_write=1 and wb_sel=10. pc_source is 1 for JAL and 0 for JALR.
- ecall 1110011 with halt_cond=1: state reaches HALT and halted=1, with no inst_done. Stays in HALT for 20 cycles of random inputs. With halt_cond=0 the controller returns to IF.
- Reset driven low mid-MEM during a store wait: mem_write drops in the same cycle and state=0. After release, a fresh fetch starts with iord=0.
